// File: rtl/dtc_pkg.sv
// Shared constants and types for the dtc confusion-matrix collector.
// Class-code width, matrix geometry and the collector FSM states.
package dtc_pkg;

    localparam int CLS_W       = 2;
    localparam int NUM_CLASSES = 2 ** CLS_W;
    localparam int IDX_W       = 2 * CLS_W;
    localparam int NUM_CELLS   = NUM_CLASSES * NUM_CLASSES;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        REPORT,
        DONE
    } state_e;

    // Matrix cell index: row = true label, column = prediction.
    function automatic logic [IDX_W-1:0] cell_idx(
        input logic [CLS_W-1:0] label,
        input logic [CLS_W-1:0] pred
    );
        return {label, pred};
    endfunction

endpackage

// File: rtl/dtc_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst (sync, active-high), clr, inc, q (count), at_max (q is all ones).
module dtc_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         at_max
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign at_max = &cnt_q;
    assign q      = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !at_max) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dtc_confusion_collector.sv
// Collects (prediction, label) pairs into a saturating 4x4 confusion matrix
// with total/correct counts, then streams the matrix out after the last sample.
// Ports: clk, rst (sync, active-high), start; input stream in_valid/in_ready/
// in_pred/in_label/in_last; output stream out_valid/out_ready/out_idx/out_data;
// status total_cnt, correct_cnt, sat (sticky per batch), done (1-cycle pulse).
module dtc_confusion_collector
    import dtc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CLS_W-1:0] in_pred,
    input  logic [CLS_W-1:0] in_label,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [CNT_W-1:0] out_data,
    output logic [CNT_W-1:0] total_cnt,
    output logic [CNT_W-1:0] correct_cnt,
    output logic             sat,
    output logic             done
);

    state_e           state_q;
    state_e           state_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic             sat_q;
    logic             sat_d;

    logic [CNT_W-1:0]     cell_q [NUM_CELLS];
    logic [NUM_CELLS-1:0] cell_inc;
    logic [NUM_CELLS-1:0] cell_max;

    logic             clr;
    logic             in_hs;
    logic             out_hs;
    logic             is_corr;
    logic             tot_max;
    logic             corr_max;
    logic             sat_hit;
    logic [IDX_W-1:0] in_idx;

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == REPORT);
    assign done      = (state_q == DONE);
    assign clr       = (state_q == CLEAR);
    assign out_idx   = idx_q;
    assign out_data  = cell_q[idx_q];
    assign sat       = sat_q;

    assign in_hs   = in_valid && in_ready;
    assign out_hs  = out_valid && out_ready;
    assign in_idx  = cell_idx(in_label, in_pred);
    assign is_corr = (in_pred == in_label);

    always_comb begin
        cell_inc = '0;
        if (in_hs) begin
            cell_inc[in_idx] = 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cell
        dtc_sat_counter #(.W(CNT_W)) u_cell (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr),
            .inc    (cell_inc[i]),
            .q      (cell_q[i]),
            .at_max (cell_max[i])
        );
    end

    dtc_sat_counter #(.W(CNT_W)) u_total (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .inc    (in_hs),
        .q      (total_cnt),
        .at_max (tot_max)
    );

    dtc_sat_counter #(.W(CNT_W)) u_correct (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .inc    (in_hs && is_corr),
        .q      (correct_cnt),
        .at_max (corr_max)
    );

    // Any increment attempted on a counter already at max flags saturation.
    assign sat_hit = in_hs
                   && (cell_max[in_idx] || tot_max || (is_corr && corr_max));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sat_d   = sat_q;
        if (clr) begin
            sat_d = 1'b0;
        end else if (sat_hit) begin
            sat_d = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = ACCUM;
            end
            ACCUM: begin
                if (in_hs && in_last) begin
                    state_d = REPORT;
                    idx_d   = '0;
                end
            end
            REPORT: begin
                if (out_hs) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_W'(NUM_CELLS - 1)) begin
                        state_d = DONE;
                        idx_d   = '0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sat_q   <= sat_d;
        end
    end

endmodule

// File: tb/tb_dtc_confusion_collector.sv
// Directed self-checking bench for dtc_confusion_collector (CNT_W=4 so that
// saturation is reachable with a short stimulus).
module tb_dtc_confusion_collector;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_pred = '0;
    logic [1:0]       in_label = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [3:0]       out_idx;
    logic [CNT_W-1:0] out_data;
    logic [CNT_W-1:0] total_cnt;
    logic [CNT_W-1:0] correct_cnt;
    logic             sat;
    logic             done;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    logic [CNT_W-1:0] got [16];
    logic [CNT_W-1:0] exp [16];
    bit   order_ok, stable_ok, timeout, early_done;
    bit   done_after, done_next, ov_after;
    logic [3:0] idx_after;
    int   hs_n;

    dtc_confusion_collector #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pred     (in_pred),
        .in_label    (in_label),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_idx     (out_idx),
        .out_data    (out_data),
        .total_cnt   (total_cnt),
        .correct_cnt (correct_cnt),
        .sat         (sat),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    task automatic send(input logic [1:0] p, input logic [1:0] l,
                        input logic last);
        in_valid = 1'b1;
        in_pred  = p;
        in_label = l;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 16; i++) exp[i] = '0;
    endtask

    // Runs the report phase, recording entries and handshake properties.
    task automatic drain(input int stall_at, input int stall_n, input bit rnd);
        int cyc = 0;
        int stalled = 0;
        bit waiting = 0;
        bit rdy;
        logic [3:0]       pidx = '0;
        logic [CNT_W-1:0] pdata = '0;
        hs_n = 0;
        order_ok = 1;
        stable_ok = 1;
        early_done = 0;
        timeout = 0;
        while (hs_n < 16 && cyc < 400) begin
            if (done) early_done = 1;
            if (!out_valid) order_ok = 0;
            if (waiting && (out_idx !== pidx || out_data !== pdata))
                stable_ok = 0;
            if (out_idx == 4'(stall_at) && stalled < stall_n) begin
                rdy = 0;
                stalled++;
            end else if (rnd) begin
                rdy = 1'($urandom_range(0, 1));
            end else begin
                rdy = 1;
            end
            out_ready = rdy;
            if (out_valid && rdy) begin
                if (out_idx !== 4'(hs_n)) order_ok = 0;
                got[hs_n] = out_data;
                hs_n++;
                waiting = 0;
            end else begin
                waiting = out_valid;
                pidx = out_idx;
                pdata = out_data;
            end
            step();
            cyc++;
        end
        out_ready = 1'b0;
        if (cyc >= 400) timeout = 1;
        done_after = done;
        ov_after = out_valid;
        idx_after = out_idx;
        step();
        done_next = done;
    endtask

    task automatic check_report(input string nm);
        tests++;
        if (timeout || hs_n != 16) begin
            fails++;
            $display("FAIL %s handshakes: got %0d, want 16", nm, hs_n);
        end
        tests++;
        if (!order_ok || early_done) begin
            fails++;
            $display("FAIL %s order: order_ok=%0d early_done=%0d, want 1/0",
                     nm, order_ok, early_done);
        end
        for (int i = 0; i < 16; i++) begin
            tests++;
            if (got[i] !== exp[i]) begin
                fails++;
                $display("FAIL %s cell%0d: got %0d, want %0d",
                         nm, i, got[i], exp[i]);
            end
        end
        tests++;
        if (done_after !== 1'b1 || ov_after !== 1'b0 || idx_after !== 4'd0) begin
            fails++;
            $display("FAIL %s done: done=%0d ov=%0d idx=%0d, want 1/0/0",
                     nm, done_after, ov_after, idx_after);
        end
        tests++;
        if (done_next !== 1'b0) begin
            fails++;
            $display("FAIL %s done_width: got %0d, want 0", nm, done_next);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tests++;
        if (total_cnt !== '0 || correct_cnt !== '0 || sat !== 1'b0) begin
            fails++;
            $display("FAIL reset_cnt: total=%0d correct=%0d sat=%0d, want 0",
                     total_cnt, correct_cnt, sat);
        end
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_idx !== 4'd0
            || done !== 1'b0 || out_data !== '0) begin
            fails++;
            $display("FAIL reset_out: rdy=%0d ov=%0d idx=%0d done=%0d data=%0d",
                     in_ready, out_valid, out_idx, done, out_data);
        end
    endtask

    task automatic test_abort();
        int d0;
        do_start();
        send(2'd0, 2'd0, 1'b0);
        send(2'd1, 2'd2, 1'b0);
        send(2'd3, 2'd3, 1'b0);
        tests++;
        if (total_cnt !== 4'd3 || correct_cnt !== 4'd2) begin
            fails++;
            $display("FAIL abort_pre: total=%0d correct=%0d, want 3/2",
                     total_cnt, correct_cnt);
        end
        d0 = done_cnt;
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++;
        if (total_cnt !== '0 || correct_cnt !== '0 || in_ready !== 1'b0
            || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL abort_rst: total=%0d correct=%0d rdy=%0d ov=%0d",
                     total_cnt, correct_cnt, in_ready, out_valid);
        end
        repeat (3) step();
        tests++;
        if (done_cnt != d0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL abort_done: pulses=%0d rdy=%0d, want 0/0",
                     done_cnt - d0, in_ready);
        end
        do_start();
        send(2'd2, 2'd3, 1'b0);
        send(2'd0, 2'd0, 1'b1);
        tests++;
        if (total_cnt !== 4'd2 || correct_cnt !== 4'd1) begin
            fails++;
            $display("FAIL abort_new: total=%0d correct=%0d, want 2/1",
                     total_cnt, correct_cnt);
        end
        clear_exp();
        exp[14] = 4'd1;
        exp[0]  = 4'd1;
        drain(99, 0, 1'b0);
        check_report("abort");
    endtask

    task automatic test_basic();
        do_start();
        send(2'd0, 2'd0, 1'b0);
        send(2'd1, 2'd1, 1'b0);
        send(2'd2, 2'd1, 1'b0);
        send(2'd3, 2'd3, 1'b1);
        tests++;
        if (total_cnt !== 4'd4 || correct_cnt !== 4'd3 || sat !== 1'b0) begin
            fails++;
            $display("FAIL basic_cnt: total=%0d correct=%0d sat=%0d, want 4/3/0",
                     total_cnt, correct_cnt, sat);
        end
        tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_idx !== 4'd0) begin
            fails++;
            $display("FAIL basic_rep: ov=%0d rdy=%0d idx=%0d, want 1/0/0",
                     out_valid, in_ready, out_idx);
        end
        clear_exp();
        exp[0]  = 4'd1;
        exp[5]  = 4'd1;
        exp[6]  = 4'd1;
        exp[15] = 4'd1;
        drain(99, 0, 1'b0);
        check_report("basic");
    endtask

    task automatic test_backpressure();
        do_start();
        send(2'd3, 2'd0, 1'b0);
        send(2'd0, 2'd3, 1'b0);
        send(2'd3, 2'd0, 1'b0);
        send(2'd2, 2'd1, 1'b1);
        clear_exp();
        exp[3]  = 4'd2;
        exp[12] = 4'd1;
        exp[6]  = 4'd1;
        drain(3, 5, 1'b1);
        tests++;
        if (!stable_ok) begin
            fails++;
            $display("FAIL bp_stable: got unstable, want stable idx/data");
        end
        check_report("bp");
    endtask

    task automatic test_saturation();
        do_start();
        for (int i = 0; i < 20; i++) send(2'd2, 2'd2, (i == 19));
        tests++;
        if (total_cnt !== 4'd15 || correct_cnt !== 4'd15 || sat !== 1'b1) begin
            fails++;
            $display("FAIL sat_cnt: total=%0d correct=%0d sat=%0d, want 15/15/1",
                     total_cnt, correct_cnt, sat);
        end
        clear_exp();
        exp[10] = 4'd15;
        drain(99, 0, 1'b0);
        check_report("sat");
        tests++;
        if (sat !== 1'b1 || total_cnt !== 4'd15) begin
            fails++;
            $display("FAIL sat_hold: sat=%0d total=%0d, want 1/15",
                     sat, total_cnt);
        end
        do_start();
        tests++;
        if (sat !== 1'b0 || total_cnt !== '0 || correct_cnt !== '0) begin
            fails++;
            $display("FAIL sat_clear: sat=%0d total=%0d correct=%0d, want 0",
                     sat, total_cnt, correct_cnt);
        end
    endtask

    // Entered with a freshly started batch in ACCUM.
    task automatic test_start_ignored();
        start = 1'b1;
        step();
        start = 1'b0;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL ign_accum: in_ready=%0d, want 1", in_ready);
        end
        send(2'd1, 2'd0, 1'b1);
        out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_idx !== 4'd0 || total_cnt !== 4'd1
            || correct_cnt !== 4'd0) begin
            fails++;
            $display("FAIL ign_report: ov=%0d idx=%0d total=%0d correct=%0d",
                     out_valid, out_idx, total_cnt, correct_cnt);
        end
        clear_exp();
        exp[1] = 4'd1;
        drain(99, 0, 1'b0);
        check_report("single");
    endtask

    task automatic test_valid_blocked();
        in_valid = 1'b1;
        in_pred  = 2'd0;
        in_label = 2'd0;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (in_ready !== 1'b0) begin
                fails++;
                $display("FAIL idle_rdy: got %0d, want 0", in_ready);
            end
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        tests++;
        if (total_cnt !== 4'd1 || correct_cnt !== 4'd0) begin
            fails++;
            $display("FAIL idle_cnt: total=%0d correct=%0d, want 1/0",
                     total_cnt, correct_cnt);
        end
        do_start();
        send(2'd3, 2'd3, 1'b1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pred   = 2'd3;
        in_label  = 2'd3;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (in_ready !== 1'b0) begin
                fails++;
                $display("FAIL rep_rdy: got %0d, want 0", in_ready);
            end
            step();
        end
        in_valid = 1'b0;
        tests++;
        if (total_cnt !== 4'd1 || correct_cnt !== 4'd1) begin
            fails++;
            $display("FAIL rep_cnt: total=%0d correct=%0d, want 1/1",
                     total_cnt, correct_cnt);
        end
        clear_exp();
        exp[15] = 4'd1;
        drain(99, 0, 1'b0);
        check_report("blocked");
    endtask

    initial begin
        test_reset();
        test_abort();
        test_basic();
        test_backpressure();
        test_saturation();
        test_start_ignored();
        test_valid_blocked();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
